// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM encoding and sizing helpers for the OFM write path.
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  function automatic int total_words(input int co, input int ofm);
    return co * ofm * ofm;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ofm_fifo.sv
// ofm_fifo: synchronous FIFO with flush; caller must not push when full unless popping.
module ofm_fifo
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PW = clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW:0] wr_q, rd_q;
  assign dout_o  = mem_q[rd_q[PW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  always_ff @(posedge clk_i)
    if (push_i && !flush_i) mem_q[wr_q[PW-1:0]] <= din_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (PW+1)'(push_i);
      rd_q <= rd_q + (PW+1)'(pop_i);
    end
endmodule

// File: rtl/ofm_writer.sv
// ofm_writer: buffers result words and writes them to OFM SRAM at filter/row/column-major addresses.
// Define OFM_RELU_EN to write negative words as zero.
module ofm_writer
  import cnn_pkg::*;
#(
  parameter int OFM_SIZE   = 16,
  parameter int CO         = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start_conv,
  input  logic              end_conv,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              incomplete
);
  localparam int SW = clog2(OFM_SIZE + 1);
  localparam int FW = clog2(CO + 1);
  state_e st_q, st_d;
  logic wr_en_q, wr_en_d, ovf_q, ovf_d, inc_q, inc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, fifo_dout, head;
  logic [SW-1:0] col_q, col_d, row_q, row_d;
  logic [FW-1:0] flt_q, flt_d;
  logic active, accept, col_wrap, row_wrap, fin, pop, push, drop, flush, full, empty;
  ofm_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk1), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
    .din_i(out_data), .dout_o(fifo_dout), .full_o(full), .empty_o(empty)
  );
`ifdef OFM_RELU_EN
  assign head = fifo_dout[DATA_W-1] ? '0 : fifo_dout;
`else
  assign head = fifo_dout;
`endif
  // fin marks the acceptance of the last word of the map; nothing is popped after it
  always_comb begin
    active   = st_q == RUN || st_q == DRAIN;
    accept   = wr_en_q && mem_ready;
    col_wrap = col_q == SW'(OFM_SIZE - 1);
    row_wrap = row_q == SW'(OFM_SIZE - 1);
    fin      = active && accept && col_wrap && row_wrap && flt_q == FW'(CO - 1);
    pop      = active && !start_conv && !empty && (!wr_en_q || mem_ready) && !fin;
    push     = active && !start_conv && out_valid && (!full || pop);
    drop     = active && !start_conv && out_valid && full && !pop;
    st_d     = start_conv ? RUN :
               st_q == RUN ? (fin ? DONE : end_conv ? DRAIN : RUN) :
               st_q == DRAIN ? ((fin || (empty && !wr_en_q)) ? DONE : DRAIN) :
               st_q == DONE ? IDLE : st_q;
    flush    = start_conv || st_d == DONE;
    ovf_d    = start_conv ? 1'b0 : ovf_q | drop | (fin & (!empty | push));
    inc_d    = start_conv ? 1'b0 : inc_q | (st_q == DRAIN && st_d == DONE && !fin);
    wr_en_d  = start_conv ? 1'b0 : pop ? 1'b1 : accept ? 1'b0 : wr_en_q;
    wdata_d  = start_conv ? '0 : pop ? head : wdata_q;
    addr_d   = start_conv ? '0 : accept ? addr_q + ADDR_W'(1) : addr_q;
    col_d    = start_conv ? '0 : accept ? (col_wrap ? '0 : col_q + SW'(1)) : col_q;
    row_d    = start_conv ? '0 : (accept && col_wrap) ? (row_wrap ? '0 : row_q + SW'(1)) : row_q;
    flt_d    = start_conv ? '0 : (accept && col_wrap && row_wrap) ? flt_q + FW'(1) : flt_q;
  end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      st_q    <= IDLE;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      flt_q   <= '0;
      ovf_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      flt_q   <= flt_d;
      ovf_q   <= ovf_d;
      inc_q   <= inc_d;
    end
  assign mem_wr_en  = wr_en_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = active;
  assign done       = st_q == DONE;
  assign overflow   = ovf_q;
  assign incomplete = inc_q;
endmodule

// File: tb/tb_ofm_writer.sv
// tb_ofm_writer: directed scenario tasks for ofm_writer with a write-log monitor.
module tb_ofm_writer;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TOTAL = 1024;
  logic clk1 = 0, rst_n = 1, start_conv = 0, end_conv = 0, out_valid = 0, mem_ready = 0;
  logic [DW-1:0] out_data = '0;
  logic mem_wr_en, busy, done, overflow, incomplete;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  int passed = 0, total = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  int done_cnt = 0, stall_err = 0;
  logic stall_p = 0;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;

  ofm_writer dut (
    .clk1(clk1), .rst_n(rst_n), .start_conv(start_conv), .end_conv(end_conv),
    .out_valid(out_valid), .out_data(out_data), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .overflow(overflow), .incomplete(incomplete)
  );

  always #5 clk1 = ~clk1;

  // inputs change 1 time unit after posedge, so negedge sees what the next posedge will see
  always @(negedge clk1) begin
    if (stall_p && (!mem_wr_en || mem_addr !== pa || mem_wdata !== pd)) stall_err++;
    stall_p = mem_wr_en && !mem_ready;
    pa = mem_addr;
    pd = mem_wdata;
    if (mem_wr_en && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] v;
    v = i * 40503 + 17;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef OFM_RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_logs;
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
    stall_err = 0;
  endtask

  task automatic start;
    start_conv = 1;
    tick;
    start_conv = 0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) tick;
    repeat (3) tick;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      out_valid = 1;
      out_data = pat(base + i);
      tick;
    end
    out_valid = 0;
  endtask

  task automatic check_log(input string name, input int base, input int n);
    int ae, de;
    ae = 0;
    de = 0;
    for (int k = 0; k < log_addr.size() && k < n; k++) begin
      if (log_addr[k] !== AW'(k)) ae++;
      if (log_data[k] !== relu(pat(base + k))) de++;
    end
    total++;
    if (log_addr.size() !== n) $display("FAIL %s count: got %0d exp %0d", name, log_addr.size(), n);
    else passed++;
    total++;
    if (ae !== 0) $display("FAIL %s addr: %0d bad addresses, exp 0", name, ae);
    else passed++;
    total++;
    if (de !== 0) $display("FAIL %s data: %0d bad words, exp 0", name, de);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    total++;
    if ({mem_wr_en, busy, done, overflow, incomplete} !== 5'b0)
      $display("FAIL reset ctrl: got %b exp 00000", {mem_wr_en, busy, done, overflow, incomplete});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata} !== '0) $display("FAIL reset addr/data: got %h/%h exp 0/0", mem_addr, mem_wdata);
    else passed++;
    rst_n = 1;
    tick;
  endtask

  task automatic test_full_stream;
    clear_logs;
    mem_ready = 1;
    start;
    total++;
    if (busy !== 1'b1) $display("FAIL stream busy: got %b exp 1", busy);
    else passed++;
    push_words(0, TOTAL);
    wait_done(100);
    check_log("stream", 0, TOTAL);
    total++;
    if (done_cnt !== 1) $display("FAIL stream done: got %0d pulses exp 1", done_cnt);
    else passed++;
    total++;
    if ({overflow, incomplete, busy} !== 3'b000) $display("FAIL stream flags: got %b exp 000", {overflow, incomplete, busy});
    else passed++;
  endtask

  task automatic test_stall;
    int k;
    clear_logs;
    k = 0;
    start;
    for (int c = 0; c < 8000 && done_cnt == 0; c++) begin
      mem_ready = (c % 3) == 0;
      out_valid = (c % 4) == 0 && k < TOTAL;
      if (out_valid) begin
        out_data = pat(3000 + k);
        k++;
      end
      tick;
    end
    out_valid = 0;
    mem_ready = 1;
    repeat (3) tick;
    check_log("stall", 3000, TOTAL);
    total++;
    if (stall_err !== 0) $display("FAIL stall hold: got %0d unstable stalls exp 0", stall_err);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL stall done: got %0d pulses exp 1", done_cnt);
    else passed++;
    total++;
    if (overflow !== 1'b0) $display("FAIL stall overflow: got %b exp 0", overflow);
    else passed++;
  endtask

  task automatic test_overflow;
    clear_logs;
    mem_ready = 0;
    start;
    push_words(100, 12);
    repeat (8) tick;
    total++;
    if (overflow !== 1'b1) $display("FAIL ovf flag: got %b exp 1", overflow);
    else passed++;
    mem_ready = 1;
    end_conv = 1;
    wait_done(100);
    end_conv = 0;
    check_log("ovf", 100, 9);
    total++;
    if ({overflow, incomplete} !== 2'b11) $display("FAIL ovf flags: got %b exp 11", {overflow, incomplete});
    else passed++;
    total++;
    if (stall_err !== 0) $display("FAIL ovf hold: got %0d unstable stalls exp 0", stall_err);
    else passed++;
  endtask

  task automatic test_short_run;
    clear_logs;
    mem_ready = 1;
    start;
    total++;
    if (overflow !== 1'b0) $display("FAIL short flag clear: got %b exp 0", overflow);
    else passed++;
    push_words(500, 300);
    end_conv = 1;
    wait_done(100);
    end_conv = 0;
    check_log("short", 500, 300);
    total++;
    if (log_addr.size() == 0 || log_addr[log_addr.size()-1] !== AW'(299))
      $display("FAIL short last addr: got %0d exp 299", log_addr.size() == 0 ? -1 : int'(log_addr[log_addr.size()-1]));
    else passed++;
    total++;
    if ({done_cnt == 1, incomplete, overflow} !== 3'b110)
      $display("FAIL short flags: done_cnt=%0d inc=%b ovf=%b exp 1/1/0", done_cnt, incomplete, overflow);
    else passed++;
  endtask

  task automatic test_relu;
    logic [DW-1:0] e0, e1;
`ifdef OFM_RELU_EN
    e0 = 16'h0000;
`else
    e0 = 16'h8001;
`endif
    e1 = 16'h7FFF;
    clear_logs;
    mem_ready = 1;
    start;
    out_valid = 1;
    out_data = 16'h8001;
    tick;
    out_data = 16'h7FFF;
    tick;
    out_valid = 0;
    end_conv = 1;
    wait_done(50);
    end_conv = 0;
    total++;
    if (log_data.size() !== 2) $display("FAIL relu count: got %0d exp 2", log_data.size());
    else passed++;
    total++;
    if (log_data.size() < 2 || log_data[0] !== e0 || log_data[1] !== e1)
      $display("FAIL relu data: got %h,%h exp %h,%h", log_data.size() > 0 ? log_data[0] : 16'hx,
               log_data.size() > 1 ? log_data[1] : 16'hx, e0, e1);
    else passed++;
  endtask

  task automatic test_reset_midjob;
    clear_logs;
    mem_ready = 0;
    start;
    push_words(700, 6);
    tick;
    total++;
    if ({busy, mem_wr_en} !== 2'b11) $display("FAIL midrst pre: got %b exp 11", {busy, mem_wr_en});
    else passed++;
    rst_n = 0;
    @(negedge clk1);
    total++;
    if ({mem_wr_en, busy, done, overflow, incomplete, mem_addr, mem_wdata} !== '0)
      $display("FAIL midrst outputs: wr=%b busy=%b addr=%h data=%h exp all 0", mem_wr_en, busy, mem_addr, mem_wdata);
    else passed++;
    tick;
    mem_ready = 1;
    tick;
    rst_n = 1;
    repeat (6) tick;
    total++;
    if (log_addr.size() !== 0 || mem_wr_en !== 1'b0)
      $display("FAIL midrst writes: got %0d writes wr_en=%b exp 0/0", log_addr.size(), mem_wr_en);
    else passed++;
    clear_logs;
    start;
    push_words(900, 1);
    end_conv = 1;
    wait_done(50);
    end_conv = 0;
    check_log("restart", 900, 1);
  endtask

  initial begin
    #1;
    test_reset;
    test_full_stream;
    test_stall;
    test_overflow;
    test_short_run;
    test_relu;
    test_reset_midjob;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
